set_assoc_blockram: RTL and testbench

- Parametrised successor to the single-way dual-port block RAM; used for cache tag and data arrays.
- Holds NUMBER_WAYS ways of NUMBER_SETS elements each, implemented as block RAM.
- One read port returns every way of a set in one access. One write port updates a single way, with per-byte enables, and returns the evicted old element.
- After reset, an internal sweep sets every entry to INIT_VALUE before the array accepts traffic.

---
 rtl/set_assoc_blockram.sv | 137 +++++++++++++
 tb/tb_set_assoc_blockram.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/set_assoc_blockram.sv
// Set-associative block RAM: one read port returning every way of a set, one
// byte-masked write port returning the evicted entry, with a post-reset init sweep.
module set_assoc_blockram #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_SETS = 64,
  parameter int SET_PTR_WIDTH_IN_BITS = 6,
  parameter int NUMBER_WAYS = 4,
  parameter int WAY_PTR_WIDTH_IN_BITS = 2,
  parameter logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] INIT_VALUE = '0
) (
  input  logic                                              clk_in,
  input  logic                                              reset_in,
  output logic                                              init_done_out,
  input  logic                                              read_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                  read_set_addr_in,
  output logic [NUMBER_WAYS*SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_data_out,
  output logic                                              read_valid_out,
  input  logic                                              write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                  write_set_addr_in,
  input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]                  write_way_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS/8-1:0]          write_byte_en_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]            write_element_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]            evict_element_out,
  output logic                                              evict_valid_out
);

  localparam int E     = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int BYTES = E / 8;
  localparam logic [SET_PTR_WIDTH_IN_BITS:0] LAST_SET = (SET_PTR_WIDTH_IN_BITS+1)'(NUMBER_SETS - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                          state_reg, state_next;
  logic [SET_PTR_WIDTH_IN_BITS:0]  count_reg, count_next;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_reg <= INIT;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      INIT: begin
        count_next = count_reg + 1'b1;
        if (count_reg == LAST_SET) state_next = READY;
      end
      default: state_next = READY;
    endcase
  end

  logic sweeping, read_accept, write_accept;
  assign sweeping      = (state_reg == INIT);
  assign read_accept   = (state_reg == READY) && read_en_in;
  assign write_accept  = (state_reg == READY) && write_en_in;
  assign init_done_out = (state_reg == READY);

  // The write port is shared by the sweep and user writes.
  logic [SET_PTR_WIDTH_IN_BITS-1:0] ram_addr;
  logic [BYTES-1:0]                 ram_be;
  logic [E-1:0]                     ram_wdata;
  assign ram_addr  = sweeping ? count_reg[SET_PTR_WIDTH_IN_BITS-1:0] : write_set_addr_in;
  assign ram_be    = sweeping ? {BYTES{1'b1}} : write_byte_en_in;
  assign ram_wdata = sweeping ? INIT_VALUE : write_element_in;

  logic [E-1:0]                     read_raw  [NUMBER_WAYS];
  logic [E-1:0]                     evict_raw [NUMBER_WAYS];
  logic [BYTES-1:0]                 byp_mask_reg [NUMBER_WAYS];
  logic [E-1:0]                     byp_data_reg;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0] evict_way_reg;
  logic                             read_valid_reg, evict_valid_reg;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      byp_data_reg    <= '0;
      evict_way_reg   <= '0;
      read_valid_reg  <= 1'b0;
      evict_valid_reg <= 1'b0;
    end else begin
      read_valid_reg  <= read_accept;
      evict_valid_reg <= write_accept;
      if (read_accept)  byp_data_reg  <= write_element_in;
      if (write_accept) evict_way_reg <= write_way_in;
    end
  end

  genvar gi, bi;
  generate
    for (gi = 0; gi < NUMBER_WAYS; gi++) begin : g_way
      logic [E-1:0] mem [NUMBER_SETS];
      logic         way_we, same_set_hit;

      assign way_we       = sweeping || (write_accept && (write_way_in == WAY_PTR_WIDTH_IN_BITS'(gi)));
      assign same_set_hit = write_accept && (write_way_in == WAY_PTR_WIDTH_IN_BITS'(gi))
                            && (write_set_addr_in == read_set_addr_in);

      always_ff @(posedge clk_in) begin
        if (way_we) begin
          for (int b = 0; b < BYTES; b++) begin
            if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
          end
        end
      end

      // Both ports read-first; the written way's new bytes are patched in on output.
      always_ff @(posedge clk_in) begin
        if (reset_in) begin
          read_raw[gi]     <= '0;
          evict_raw[gi]    <= '0;
          byp_mask_reg[gi] <= '0;
        end else begin
          if (read_accept) begin
            read_raw[gi]     <= mem[read_set_addr_in];
            byp_mask_reg[gi] <= same_set_hit ? write_byte_en_in : '0;
          end
          if (write_accept) evict_raw[gi] <= mem[ram_addr];
        end
      end

      for (bi = 0; bi < BYTES; bi++) begin : g_byte
        assign read_data_out[gi*E + bi*8 +: 8] = byp_mask_reg[gi][bi] ? byp_data_reg[bi*8 +: 8]
                                                                       : read_raw[gi][bi*8 +: 8];
      end
    end
  endgenerate

  assign evict_element_out = evict_raw[evict_way_reg];
  assign read_valid_out    = read_valid_reg;
  assign evict_valid_out   = evict_valid_reg;

endmodule

// File: tb/tb_set_assoc_blockram.sv
// Randomised and directed bench for set_assoc_blockram against a per-entry array model.
module tb_set_assoc_blockram;

  logic         clk;
  logic         reset_in;
  logic         init_done;
  logic         read_en;
  logic [5:0]   read_set;
  logic [255:0] read_data;
  logic         read_valid;
  logic         write_en;
  logic [5:0]   write_set;
  logic [1:0]   write_way;
  logic [7:0]   write_be;
  logic [63:0]  write_data;
  logic [63:0]  evict_data;
  logic         evict_valid;

  set_assoc_blockram dut (
    .clk_in            (clk),
    .reset_in          (reset_in),
    .init_done_out     (init_done),
    .read_en_in        (read_en),
    .read_set_addr_in  (read_set),
    .read_data_out     (read_data),
    .read_valid_out    (read_valid),
    .write_en_in       (write_en),
    .write_set_addr_in (write_set),
    .write_way_in      (write_way),
    .write_byte_en_in  (write_be),
    .write_element_in  (write_data),
    .evict_element_out (evict_data),
    .evict_valid_out   (evict_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  logic [63:0]  model [64][4];
  logic [255:0] exp_read;

  task automatic check_value(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 4; w++) model[s][w] = 64'h0;
    exp_read = '0;
  endtask

  task automatic do_reset(input int n);
    reset_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    check_value("rst_init_done", init_done, 1'b0);
    check_value("rst_read_valid", read_valid, 1'b0);
    check_value("rst_evict_valid", evict_valid, 1'b0);
    check_value("rst_read_data", read_data, '0);
    check_value("rst_evict_data", evict_data, '0);
    @(negedge clk);
    reset_in = 1'b0;
    clear_model();
  endtask

  // Counts rising edges until init_done; optionally holds requests high throughout.
  task automatic wait_init(input bit poke);
    int cyc;
    cyc = 0;
    read_en = poke; read_set = 6'd3;
    write_en = poke; write_set = 6'd3; write_way = 2'd1; write_be = 8'hFF; write_data = 64'hDEAD_BEEF_0BAD_F00D;
    while (!init_done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (read_valid !== 1'b0) check_value("init_read_valid", read_valid, 1'b0);
      if (evict_valid !== 1'b0) check_value("init_evict_valid", evict_valid, 1'b0);
    end
    read_en = 1'b0; write_en = 1'b0;
    check_value("init_cycles", cyc, 64);
  endtask

  task automatic do_cycle(input bit re, input int rs, input bit we, input int ws, input int wy,
                          input logic [7:0] be, input logic [63:0] wd);
    logic [63:0] exp_evict;
    exp_evict = '0;
    read_en = re; read_set = 6'(rs);
    write_en = we; write_set = 6'(ws); write_way = 2'(wy); write_be = be; write_data = wd;
    if (we) begin
      exp_evict = model[ws][wy];
      for (int b = 0; b < 8; b++)
        if (be[b]) model[ws][wy][b*8 +: 8] = wd[b*8 +: 8];
    end
    if (re)
      for (int w = 0; w < 4; w++) exp_read[w*64 +: 64] = model[rs][w];
    @(posedge clk); #1;
    check_value("read_valid", read_valid, re);
    check_value("evict_valid", evict_valid, we);
    check_value("read_data", read_data, exp_read);
    if (we) check_value("evict_data", evict_data, exp_evict);
    read_en = 1'b0; write_en = 1'b0;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset_in = 1'b1; read_en = 1'b0; write_en = 1'b0;
    read_set = '0; write_set = '0; write_way = '0; write_be = '0; write_data = '0;
    clear_model();

    do_reset(3);
    wait_init(1'b1);
    do_cycle(1, 63, 0, 0, 0, 8'h00, 64'h0);
    do_cycle(1, 3, 0, 0, 0, 8'h00, 64'h0);
    check_value("init_untouched", read_data, '0);

    do_cycle(0, 0, 1, 5, 2, 8'hFF, 64'h1122334455667788);
    check_value("plan_evict0", evict_data, 64'h0);
    do_cycle(1, 5, 0, 0, 0, 8'h00, 64'h0);
    check_value("plan_read5", read_data, {64'h0, 64'h1122334455667788, 64'h0, 64'h0});
    do_cycle(0, 0, 1, 5, 2, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
    check_value("plan_evict1", evict_data, 64'h1122334455667788);
    do_cycle(1, 5, 0, 0, 0, 8'h00, 64'h0);
    check_value("plan_merge", read_data[191:128], 64'h11223344FFFFFFFF);
    do_cycle(0, 0, 1, 5, 2, 8'h00, 64'h0123_4567_89AB_CDEF);
    check_value("zero_mask_evict", evict_data, 64'h11223344FFFFFFFF);

    do_cycle(1, 9, 1, 9, 0, 8'hFF, 64'hA5);
    check_value("write_first", read_data[63:0], 64'hA5);
    do_cycle(0, 0, 1, 9, 0, 8'hFF, 64'h5A5A);
    do_cycle(0, 0, 1, 9, 0, 8'h03, 64'h7777);
    check_value("b2b_evict", evict_data, 64'h5A5A);
    do_cycle(0, 0, 0, 0, 0, 8'h00, 64'h0);

    for (int i = 0; i < 400; i++) begin
      do_cycle($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
               $urandom_range(0, 7), $urandom_range(0, 3), 8'($urandom), {$urandom, $urandom});
    end

    do_cycle(0, 0, 1, 20, 1, 8'hFF, 64'hCAFE_F00D_1234_5678);
    do_reset(2);
    repeat (30) @(posedge clk);
    #1;
    check_value("mid_sweep_done", init_done, 1'b0);
    do_reset(2);
    wait_init(1'b0);
    do_cycle(1, 20, 0, 0, 0, 8'h00, 64'h0);
    check_value("resweep_clear", read_data, '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
